// File: rtl/distance_display.sv
// Distance readout: 12-bit binary to 4-digit BCD (double dabble) plus a multiplexed
// active-low 7-segment scanner. Optional leading-zero blanking via DIST_BLANK_ZEROS_EN.
module distance_display #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [11:0] binary_distance,
    output logic [15:0] bcd_out,
    output logic        bcd_valid,
    output logic [3:0]  an_out,
    output logic [6:0]  seg_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        LOAD    = 2'd2
    } state_t;

    localparam logic [21:0] SCAN_LAST = 22'(SCAN_DIV - 1);

    state_t      state_r;
    logic [11:0] last_r;
    logic [11:0] shift_r;
    logic [15:0] acc_r;
    logic [3:0]  iter_r;
    logic [21:0] prescale_r;
    logic [1:0]  idx_r;

    logic [15:0] adj_acc_s;
    logic [27:0] shift_all_s;
    logic [3:0]  nibble_s;
    logic        blank_s;

    function automatic logic [3:0] add3_nibble(input logic [3:0] n);
        if (n >= 4'd5) begin
            return n + 4'd3;
        end else begin
            return n;
        end
    endfunction

    function automatic logic [15:0] dabble_adjust(input logic [15:0] acc);
        logic [15:0] res;
        res = acc;
        for (int i = 0; i < 4; i++) begin
            res[i*4 +: 4] = add3_nibble(acc[i*4 +: 4]);
        end
        return res;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [3:0] an_decode(input logic [1:0] idx);
        case (idx)
            2'd0:    return 4'b1110;
            2'd1:    return 4'b1101;
            2'd2:    return 4'b1011;
            2'd3:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    // One double-dabble step: correct nibbles, then shift {acc, shift} left by one
    always_comb begin
        adj_acc_s   = dabble_adjust(acc_r);
        shift_all_s = {adj_acc_s, shift_r} << 1;
    end

    // Select the displayed nibble and decide whether it is a leading zero
    always_comb begin
        nibble_s = 4'd0;
        blank_s  = 1'b0;
        case (idx_r)
            2'd0:    nibble_s = bcd_out[3:0];
            2'd1:    nibble_s = bcd_out[7:4];
            2'd2:    nibble_s = bcd_out[11:8];
            2'd3:    nibble_s = bcd_out[15:12];
            default: nibble_s = 4'd0;
        endcase
`ifdef DIST_BLANK_ZEROS_EN
        case (idx_r)
            2'd1:    blank_s = (bcd_out[15:4] == 12'd0);
            2'd2:    blank_s = (bcd_out[15:8] == 8'd0);
            2'd3:    blank_s = (bcd_out[15:12] == 4'd0);
            default: blank_s = 1'b0;
        endcase
`else
        blank_s = 1'b0;
`endif
    end

    // Converter FSM; bcd_valid defaults low so it is a single-cycle pulse from LOAD
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_r   <= IDLE;
            last_r    <= 12'd0;
            shift_r   <= 12'd0;
            acc_r     <= 16'd0;
            iter_r    <= 4'd0;
            bcd_out   <= 16'd0;
            bcd_valid <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (binary_distance != last_r) begin
                        shift_r <= binary_distance;
                        last_r  <= binary_distance;
                        acc_r   <= 16'd0;
                        iter_r  <= 4'd0;
                        state_r <= CONVERT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CONVERT: begin
                    acc_r   <= shift_all_s[27:12];
                    shift_r <= shift_all_s[11:0];
                    iter_r  <= iter_r + 4'd1;
                    if (iter_r == 4'd11) begin
                        state_r <= LOAD;
                    end else begin
                        state_r <= CONVERT;
                    end
                end
                LOAD: begin
                    bcd_out   <= acc_r;
                    bcd_valid <= 1'b1;
                    state_r   <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Scan prescaler and digit index
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            prescale_r <= 22'd0;
            idx_r      <= 2'd0;
        end else if (prescale_r == SCAN_LAST) begin
            prescale_r <= 22'd0;
            idx_r      <= idx_r + 2'd1;
        end else begin
            prescale_r <= prescale_r + 22'd1;
        end
    end

    // Registered digit drive, one cycle behind the index
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            an_out  <= 4'b1111;
            seg_out <= 7'b1111111;
        end else begin
            an_out <= an_decode(idx_r);
            if (blank_s) begin
                seg_out <= 7'b1111111;
            end else begin
                seg_out <= seg_decode(nibble_s);
            end
        end
    end

endmodule

// File: tb/tb_distance_display.sv
// Directed bench for distance_display (SCAN_DIV=4); expectations follow DIST_BLANK_ZEROS_EN.
module tb_distance_display;

    logic        clk;
    logic        n_rst;
    logic [11:0] binary_distance;
    logic [15:0] bcd_out;
    logic        bcd_valid;
    logic [3:0]  an_out;
    logic [6:0]  seg_out;

    int checks;
    int errors;
    int pulses;

`ifdef DIST_BLANK_ZEROS_EN
    localparam logic [6:0] HI_ZERO = 7'b1111111;
`else
    localparam logic [6:0] HI_ZERO = 7'b1000000;
`endif

    distance_display #(.SCAN_DIV(4)) dut (
        .clk(clk),
        .n_rst(n_rst),
        .binary_distance(binary_distance),
        .bcd_out(bcd_out),
        .bcd_valid(bcd_valid),
        .an_out(an_out),
        .seg_out(seg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Edge 0 samples the new value; result must appear after edge 13 only
    task automatic convert_check(input string tag, input logic [11:0] value,
                                 input logic [15:0] old_bcd, input logic [15:0] exp_bcd);
        binary_distance = value;
        pulses = 0;
        for (int i = 0; i <= 12; i++) begin
            tick;
            if (bcd_valid) pulses++;
        end
        check({tag, "_early_pulse"}, pulses, 0);
        check({tag, "_held"}, bcd_out, old_bcd);
        tick;
        check({tag, "_valid"}, bcd_valid, 1'b1);
        check({tag, "_bcd"}, bcd_out, exp_bcd);
        tick;
        check({tag, "_valid_low"}, bcd_valid, 1'b0);
    endtask

    task automatic scan_check(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
        logic [6:0] segs [4];
        logic [3:0] exp_an;
        int found;
        segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
        found = 0;
        for (int k = 0; k < 64 && found == 0; k++) begin
            if (an_out === 4'b0111) found = 1;
            else tick;
        end
        check({tag, "_wait3"}, found, 1);
        found = 0;
        for (int k = 0; k < 64 && found == 0; k++) begin
            if (an_out === 4'b1110) found = 1;
            else tick;
        end
        check({tag, "_wait0"}, found, 1);
        for (int i = 0; i < 16; i++) begin
            exp_an = ~(4'b0001 << (i / 4));
            check($sformatf("%s_an%0d", tag, i), an_out, exp_an);
            check($sformatf("%s_seg%0d", tag, i), seg_out, segs[i / 4]);
            tick;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        n_rst = 1'b0;
        binary_distance = 12'd4095;

        for (int i = 0; i < 3; i++) begin
            tick;
            check("rst_bcd", bcd_out, 16'h0000);
            check("rst_valid", bcd_valid, 1'b0);
            check("rst_an", an_out, 4'b1111);
            check("rst_seg", seg_out, 7'b1111111);
        end

        binary_distance = 12'd0;
        n_rst = 1'b1;
        tick;
        check("rel_an", an_out, 4'b1110);
        check("rel_seg", seg_out, 7'b1000000);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (bcd_valid) pulses++;
        end
        check("zero_no_conv", pulses, 0);

        convert_check("c4095", 12'd4095, 16'h0000, 16'h4095);
        convert_check("c0", 12'd0, 16'h4095, 16'h0000);

        // 100 then 257 five cycles later: second value waits for the next IDLE
        binary_distance = 12'd100;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (bcd_valid) pulses++;
        end
        binary_distance = 12'd257;
        for (int i = 5; i <= 12; i++) begin
            tick;
            if (bcd_valid) pulses++;
        end
        check("seq_early", pulses, 0);
        tick;
        if (bcd_valid) pulses++;
        check("seq_100_valid", bcd_valid, 1'b1);
        check("seq_100_bcd", bcd_out, 16'h0100);
        for (int i = 14; i <= 26; i++) begin
            tick;
            if (bcd_valid) pulses++;
        end
        check("seq_mid_pulses", pulses, 1);
        check("seq_mid_bcd", bcd_out, 16'h0100);
        tick;
        if (bcd_valid) pulses++;
        check("seq_257_valid", bcd_valid, 1'b1);
        check("seq_257_bcd", bcd_out, 16'h0257);
        for (int i = 0; i < 20; i++) begin
            tick;
            if (bcd_valid) pulses++;
        end
        check("seq_total_pulses", pulses, 2);

        convert_check("c1234", 12'd1234, 16'h0257, 16'h1234);
        scan_check("scan1234", 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);

        convert_check("c7", 12'd7, 16'h1234, 16'h0007);
        scan_check("scan7", 7'b1111000, HI_ZERO, HI_ZERO, HI_ZERO);

        convert_check("c0b", 12'd0, 16'h0007, 16'h0000);
        scan_check("scan0", 7'b1000000, HI_ZERO, HI_ZERO, HI_ZERO);

        // Reset in the middle of a conversion must abandon it
        binary_distance = 12'd1234;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (bcd_valid) pulses++;
        end
        n_rst = 1'b0;
        binary_distance = 12'd0;
        tick;
        check("midrst_valid", bcd_valid, 1'b0);
        check("midrst_bcd", bcd_out, 16'h0000);
        check("midrst_an", an_out, 4'b1111);
        n_rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (bcd_valid) pulses++;
        end
        check("midrst_pulses", pulses, 0);
        check("midrst_bcd_after", bcd_out, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/distance_display.md
DISTANCE_DISPLAY -- requirements
Module: distance_display

Interface
REQ-001 SCAN_DIV, 50000, clock cycles each digit is active in the scan; legal range 2..4194303; internal prescaler is 22 bits.
REQ-002 clk  input  1  system clock (50 MHz nominal); all logic on rising edge.
REQ-003 n_rst  input  1  reset, synchronous, active-low.
REQ-004 binary_distance  input  12  unsigned distance from the upstream sensor interface, 0..4095.
REQ-005 bcd_out  output  16  four BCD digits of the last converted value; [3:0] units, [15:12] thousands.
REQ-006 bcd_valid  output  1  one-cycle pulse when bcd_out takes a new value.
REQ-007 an_out  output  4  digit enable, active-low one-hot; bit 0 selects units.
REQ-008 seg_out  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}.

Function
REQ-009 Converter FSM states: IDLE, CONVERT, LOAD.
REQ-010 IDLE: if binary_distance differs from last_value, latch it into shift_reg and last_value, clear the 16-bit BCD accumulator and the iteration counter, go to CONVERT; otherwise stay in IDLE.
REQ-011 CONVERT: one iteration per cycle (double dabble). Add 3 to each accumulator nibble whose value is 5 or more, then shift {accumulator, shift_reg} left by one.
REQ-012 CONVERT ends after exactly 12 iterations, then goes to LOAD.
REQ-013 LOAD: bcd_out <= accumulator, bcd_valid high for that one cycle, go to IDLE.
REQ-014 Latency: call the IDLE sampling edge edge 0. New bcd_out and bcd_valid appear after edge 13. bcd_valid is low in every other cycle.
REQ-015 Input changes during CONVERT or LOAD are ignored. The next IDLE cycle compares against last_value and starts a new conversion if the value differs.
REQ-016 A stable input gives no further conversions and no bcd_valid pulses.
REQ-017 Scanner: prescaler counts 0..SCAN_DIV-1 and wraps. At its terminal count, digit index (2 bits) increments and wraps 3->0.
REQ-018 an_out and seg_out are registered from the digit index and the selected bcd_out nibble, one cycle behind the index.
REQ-019 Index 0 -> an_out 1110, index 1 -> 1101, index 2 -> 1011, index 3 -> 0111.
REQ-020 Segment codes:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- nibbles 10..15 (unreachable) = 1111111
REQ-021 The scanner reads bcd_out only, so a mid-conversion display shows the previous value and never shows a partial one.

Reset
REQ-022 While n_rst is low at a rising edge, the following load their reset values:
- state = IDLE, last_value = 0, shift_reg = 0, accumulator = 0
- bcd_out = 0, bcd_valid = 0
- prescaler = 0, digit index = 0, an_out = 1111, seg_out = 1111111
REQ-023 Reset asserted mid-conversion abandons the conversion, with no bcd_valid pulse. An input of 0 after reset needs no conversion.
REQ-024 At the first edge after release: an_out = 1110, seg_out shows digit 0 of bcd_out.

Configuration
REQ-025 Macro DIST_BLANK_ZEROS_EN, when defined, enables leading-zero blanking:
- digits 3..1 whose nibble and all higher nibbles are zero drive seg_out 1111111
- the units digit is never blanked
REQ-026 When DIST_BLANK_ZEROS_EN is undefined, all four digits are always displayed. an_out is unaffected in both cases.

Verification
REQ-027 Reset: hold n_rst low 3 cycles with input 4095 -> bcd_out 0, bcd_valid 0, an_out 1111, seg_out 1111111 throughout.
REQ-028 Input 0 -> 4095 -> bcd_out 16'h4095 after edge 13 with a single bcd_valid pulse; 4095 -> 0 -> 16'h0000 with the same latency.
REQ-029 Input 100, then 257 applied 5 cycles later -> bcd_out 16'h0100 (valid pulse), then 16'h0257 (second pulse); 2 pulses total.
REQ-030 SCAN_DIV=4, value 1234 -> an_out/seg_out rotate every 4 cycles:
- 1110/0011001, 1101/0110000, 1011/0100100, 0111/1111001
REQ-031 Value 7, SCAN_DIV=4:
- with macro: digits 3..1 = 1111111, units = 1111000
- without macro: digits 3..1 = 1000000
REQ-032 Value 0 with macro -> units 1000000, others blank. Reset pulse during CONVERT -> no bcd_valid, bcd_out 0.
